// File: rtl/param_seq_shifter.sv
// param_seq_shifter: multi-cycle WIDTH-bit shift/rotate, one SHAMT bit per clock.
// Define SHIFT_STATUS_EN to add registered ZERO/CARRY status outputs.
module param_seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [1:0]         MODE,
  input  logic [SHAMT_W-1:0] SHAMT,
  input  logic [WIDTH-1:0]   DATA,
  output logic               BUSY,
  output logic               DONE,
  output logic [WIDTH-1:0]   RESULT
`ifdef SHIFT_STATUS_EN
  ,
  output logic               ZERO,
  output logic               CARRY
`endif
);

  if (SHAMT_W != $clog2(WIDTH) || WIDTH < 2 ||
      (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_param
    $error("WIDTH must be a power of two >= 2, SHAMT_W == log2(WIDTH)");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(SHAMT_W - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               sign_q, sign_d;
  logic [1:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] pend_q, pend_d;
  logic [SHAMT_W-1:0] k_q, k_d;

  logic [WIDTH-1:0]   stage;
  logic               take;
  int                 amt;

`ifdef SHIFT_STATUS_EN
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               carry_calc;
  logic [SHAMT_W-1:0] idx_l, idx_r;
`endif

  // One stage: shift/rotate by amt (a power of two) according to mode.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       m,
    input logic             sign,
    input int               a
  );
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = v << a;
      2'b01:   r = v >> a;
      2'b10:   r = (v >> a) | ({WIDTH{sign}} << (WIDTH - a));
      default: r = (v >> a) | (v << (WIDTH - a));
    endcase
    return r;
  endfunction

  // State and datapath registers; RESET wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      opr_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      mode_q   <= '0;
      pend_q   <= '0;
      k_q      <= '0;
`ifdef SHIFT_STATUS_EN
      data_q   <= '0;
      shamt_q  <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opr_q    <= opr_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      k_q      <= k_d;
`ifdef SHIFT_STATUS_EN
      data_q   <= data_d;
      shamt_q  <= shamt_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`endif
    end
  end

`ifdef SHIFT_STATUS_EN
  // Last bit shifted out, taken from the latched operand.
  always_comb begin
    carry_calc = 1'b0;
    idx_l      = SHAMT_W'(WIDTH - int'(shamt_q));
    idx_r      = shamt_q - SHAMT_W'(1);
    if (shamt_q != '0) begin
      case (mode_q)
        2'b00:   carry_calc = data_q[idx_l];
        2'b11:   carry_calc = stage[WIDTH-1];
        default: carry_calc = data_q[idx_r];
      endcase
    end
  end
`endif

  // Next-state, stage datapath and handshake outputs.
  always_comb begin
    state_d  = state_q;
    opr_d    = opr_q;
    result_d = result_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    k_d      = k_q;
`ifdef SHIFT_STATUS_EN
    data_d   = data_q;
    shamt_d  = shamt_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`endif
    BUSY     = 1'b0;
    DONE     = 1'b0;
    take     = 1'b0;
    amt      = 1 << k_q;
    stage    = pend_q[0] ? shift_stage(opr_q, mode_q, sign_q, amt) : opr_q;

    case (state_q)
      IDLE: take = START;
      SHIFT: begin
        BUSY   = 1'b1;
        opr_d  = stage;
        pend_d = pend_q >> 1;
        k_d    = k_q + SHAMT_W'(1);
        if (k_q == LAST) begin
          state_d  = FIN;
          result_d = stage;
`ifdef SHIFT_STATUS_EN
          zero_d   = (stage == '0);
          carry_d  = carry_calc;
`endif
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
        take    = START;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = SHIFT;
      opr_d   = DATA;
      sign_d  = DATA[WIDTH-1];
      mode_d  = MODE;
      pend_d  = SHAMT;
      k_d     = '0;
`ifdef SHIFT_STATUS_EN
      data_d  = DATA;
      shamt_d = SHAMT;
`endif
    end
  end

  assign RESULT = result_q;
`ifdef SHIFT_STATUS_EN
  assign ZERO   = zero_q;
  assign CARRY  = carry_q;
`endif

endmodule

// File: tb/tb_param_seq_shifter.sv
// tb_param_seq_shifter: directed checks of the sequential shifter.
// Status outputs are checked when SHIFT_STATUS_EN is defined.
module tb_param_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [2:0] shamt;
  logic [7:0] data;
  logic       busy, done;
  logic [7:0] result;

  logic        start_w;
  logic [1:0]  mode_w;
  logic [3:0]  shamt_w;
  logic [15:0] data_w;
  logic        busy_w, done_w;
  logic [15:0] result_w;

`ifdef SHIFT_STATUS_EN
  logic zero, carry, zero_w, carry_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_seq_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .CLK(clk), .RESET(rst), .START(start), .MODE(mode),
    .SHAMT(shamt), .DATA(data), .BUSY(busy), .DONE(done),
    .RESULT(result)
`ifdef SHIFT_STATUS_EN
    , .ZERO(zero), .CARRY(carry)
`endif
  );

  param_seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut_w (
    .CLK(clk), .RESET(rst), .START(start_w), .MODE(mode_w),
    .SHAMT(shamt_w), .DATA(data_w), .BUSY(busy_w), .DONE(done_w),
    .RESULT(result_w)
`ifdef SHIFT_STATUS_EN
    , .ZERO(zero_w), .CARRY(carry_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns in the first cycle after START is sampled.
  task automatic launch(input logic [1:0] m, input logic [2:0] s,
                        input logic [7:0] d);
    mode  = m;
    shamt = s;
    data  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    shamt = 3'd0;
    data = 8'h00;
    start_w = 1'b0;
    mode_w = 2'b00;
    shamt_w = 4'd0;
    data_w = 16'h0000;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 00",
               busy, done, result);
    end
    n_checks++;
    if (busy_w !== 1'b0 || done_w !== 1'b0 || result_w !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_w: busy=%b done=%b result=%h want 0 0 0000",
               busy_w, done_w, result_w);
    end
`ifdef SHIFT_STATUS_EN
    n_checks++;
    if (zero !== 1'b0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: zero=%b carry=%b want 0 0", zero, carry);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rotate();
    logic [7:0] d [3] = '{8'b0101_0001, 8'h81, 8'h01};
    logic [2:0] s [3] = '{3'd3, 3'd4, 3'd1};
    logic [7:0] e [3] = '{8'b0010_1010, 8'h18, 8'h80};
    logic       c [3] = '{1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 3; v++) begin
      launch(2'b11, s[v], d[v]);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL rot_busy v%0d c%0d: busy=%b done=%b want 1 0",
                   v, i + 1, busy, done);
        end
        tick();
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== e[v]) begin
        n_fail++;
        $display("FAIL rot_done v%0d: done=%b busy=%b result=%b want 1 0 %b",
                 v, done, busy, result, e[v]);
      end
`ifdef SHIFT_STATUS_EN
      n_checks++;
      if (carry !== c[v] || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL rot_status v%0d: carry=%b zero=%b want %b 0",
                 v, carry, zero, c[v]);
      end
`endif
      tick();
      n_checks++;
      if (done !== 1'b0 || result !== e[v]) begin
        n_fail++;
        $display("FAIL rot_pulse v%0d: done=%b result=%h want 0 %h",
                 v, done, result, e[v]);
      end
    end
  endtask

  task automatic test_arith();
    logic [7:0] d [4] = '{8'b1001_0000, 8'h70, 8'h80, 8'h85};
    logic [2:0] s [4] = '{3'd2, 3'd3, 3'd7, 3'd1};
    logic [7:0] e [4] = '{8'b1110_0100, 8'h0E, 8'hFF, 8'hC2};
    logic       c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      launch(2'b10, s[v], d[v]);
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b1 || result !== e[v]) begin
        n_fail++;
        $display("FAIL asr v%0d: done=%b result=%b want 1 %b",
                 v, done, result, e[v]);
      end
`ifdef SHIFT_STATUS_EN
      n_checks++;
      if (carry !== c[v] || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL asr_status v%0d: carry=%b zero=%b want %b 0",
                 v, carry, zero, c[v]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_left();
    logic [7:0] d [3] = '{8'b0000_0111, 8'h81, 8'h01};
    logic [2:0] s [3] = '{3'd5, 3'd1, 3'd7};
    logic [7:0] e [3] = '{8'b1110_0000, 8'h02, 8'h80};
    logic       c [3] = '{1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      launch(2'b00, s[v], d[v]);
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b1 || result !== e[v]) begin
        n_fail++;
        $display("FAIL lsl v%0d: done=%b result=%b want 1 %b",
                 v, done, result, e[v]);
      end
`ifdef SHIFT_STATUS_EN
      n_checks++;
      if (carry !== c[v] || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL lsl_status v%0d: carry=%b zero=%b want %b 0",
                 v, carry, zero, c[v]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_logical_right();
    logic [7:0] d [3] = '{8'hFF, 8'h01, 8'hF0};
    logic [2:0] s [3] = '{3'd7, 3'd1, 3'd4};
    logic [7:0] e [3] = '{8'h01, 8'h00, 8'h0F};
    logic       c [3] = '{1'b1, 1'b1, 1'b0};
    logic       z [3] = '{1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      launch(2'b01, s[v], d[v]);
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b1 || result !== e[v]) begin
        n_fail++;
        $display("FAIL lsr v%0d: done=%b result=%b want 1 %b",
                 v, done, result, e[v]);
      end
`ifdef SHIFT_STATUS_EN
      n_checks++;
      if (carry !== c[v] || zero !== z[v]) begin
        n_fail++;
        $display("FAIL lsr_status v%0d: carry=%b zero=%b want %b %b",
                 v, carry, zero, c[v], z[v]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_ignore_start();
    launch(2'b00, 3'd1, 8'h01);
    mode  = 2'b01;
    shamt = 3'd4;
    data  = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_busy: busy=%b done=%b want 1 0", busy, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'h02) begin
      n_fail++;
      $display("FAIL ign_result: done=%b result=%h want 1 02", done, result);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_noqueue: busy=%b done=%b want 0 0", busy, done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    launch(2'b01, 3'd2, 8'hF0);
    repeat (3) tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b result=%h want 1 3c", done, result);
    end
    mode  = 2'b11;
    shamt = 3'd1;
    data  = 8'h81;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h3C) begin
        n_fail++;
        $display("FAIL b2b_busy c%0d: busy=%b done=%b result=%h want 1 0 3c",
                 i + 1, busy, done, result);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || result !== 8'hC0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b result=%h want 1 c0", done, result);
    end
    tick();
  endtask

  task automatic test_shamt_zero();
    launch(2'b11, 3'd0, 8'hA5);
    repeat (2) tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sh0_early: done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'hA5) begin
      n_fail++;
      $display("FAIL sh0: done=%b result=%h want 1 a5", done, result);
    end
`ifdef SHIFT_STATUS_EN
    n_checks++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sh0_status: carry=%b zero=%b want 0 0", carry, zero);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    launch(2'b00, 3'd3, 8'h11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b result=%h want 0 0 00",
               busy, done, result);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_abort c%0d: done=%b busy=%b want 0 0",
                 i, done, busy);
      end
    end
  endtask

  task automatic test_wide();
    mode_w  = 2'b10;
    shamt_w = 4'd15;
    data_w  = 16'h8000;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy_w !== 1'b1 || done_w !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_busy c%0d: busy=%b done=%b want 1 0",
                 i + 1, busy_w, done_w);
      end
      tick();
    end
    n_checks++;
    if (done_w !== 1'b1 || result_w !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wide: done=%b result=%h want 1 ffff", done_w, result_w);
    end
`ifdef SHIFT_STATUS_EN
    n_checks++;
    if (carry_w !== 1'b0 || zero_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_status: carry=%b zero=%b want 0 0",
               carry_w, zero_w);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_arith();
    test_left();
    test_logical_right();
    test_ignore_start();
    test_back_to_back();
    test_shamt_zero();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_seq_shifter.md
Name: param_seq_shifter

Overview:
- Parametrised, multi-cycle shift/rotate unit for the ALU datapath. Generalises the 8-bit right shifter to WIDTH bits.
- Adds logical left shift.
- Adds a START/BUSY/DONE handshake so the control unit can issue shifts and wait on completion.
- Resolves one shift-amount bit per clock: stage k shifts by 2^k, LSB first. This trades latency for a single mux layer.

Parameters:
- WIDTH, 8, operand/result width; power of two, at least 2.
- SHAMT_W, 3, shift-amount width; must equal log2(WIDTH). Elaboration fails otherwise.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only while BUSY=0.
- MODE  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- SHAMT  input  SHAMT_W  shift amount, 0..WIDTH-1.
- DATA  input  WIDTH  operand.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  WIDTH  shifted value; held until the next DONE.

Behaviour:
- Reset: CLK and RESET as named above, one clock, RESET synchronous active-high.
  - On reset: state=IDLE, BUSY=0, DONE=0, RESULT=0, internal operand/stage counter = 0.
  - Reset mid-operation aborts the operation with no DONE. RESET has priority over START.
- States: IDLE, SHIFT, FIN.
- IDLE: if START=1, latch DATA, MODE, SHAMT. Set stage k=0 and go to SHIFT.
- SHIFT: BUSY=1. Each cycle:
  - If latched SHAMT[k]=1, the working operand is shifted by 2^k per MODE; otherwise it is unchanged.
  - k increments. After stage k=SHAMT_W-1, go to FIN.
- FIN: BUSY=0, DONE=1 for exactly one cycle, and RESULT is loaded on entry. Next state is IDLE, or SHIFT if START=1 (back-to-back accepted).
- Latency: START sampled at edge t gives:
  - BUSY=1 during cycles t+1..t+SHAMT_W;
  - DONE=1 and RESULT updated in cycle t+SHAMT_W+1.
  - Latency is fixed regardless of SHAMT; SHAMT=0 gives RESULT=DATA after the full latency.
- START while BUSY=1 is ignored, with no queueing. Inputs may change freely after the START cycle.
- Fill rules:
  - Logical left/right: vacated bits are 0.
  - Arithmetic right: vacated bits copy the latched DATA[WIDTH-1].
  - Rotate right: bits leaving the LSB re-enter at the MSB.
- No wrap of SHAMT beyond WIDTH-1 is possible, because the port width limits it.

Optional Feature:
- Macro SHIFT_STATUS_EN adds outputs ZERO (1 bit) and CARRY (1 bit). Both are registered alongside RESULT, updated at DONE, held otherwise, and reset to 0.
  - ZERO = (RESULT==0).
  - CARRY = last bit shifted out, computed from the latched operand:
    - left: DATA[WIDTH-SHAMT];
    - logical/arithmetic right: DATA[SHAMT-1];
    - rotate: RESULT[WIDTH-1];
    - SHAMT=0: CARRY=0.
- Without the macro these ports do not exist, and the behaviour is otherwise identical.

Test Plan:
- WIDTH=8, DATA=0101_0001, MODE=11, SHAMT=3, START at t -> BUSY cycles t+1..t+3, DONE at t+4, RESULT=0010_1010.
- MODE=10, DATA=1001_0000, SHAMT=2 -> RESULT=1110_0100.
- MODE=00, DATA=0000_0111, SHAMT=5 -> RESULT=1110_0000, CARRY=0 (with SHIFT_STATUS_EN).
- MODE=01:
  - DATA=1111_1111, SHAMT=7 -> RESULT=0000_0001, CARRY=1, ZERO=0;
  - DATA=0000_0001, SHAMT=1 -> RESULT=0, CARRY=1, ZERO=1.
- Handshake:
  - START re-asserted with new DATA while BUSY=1 -> ignored, first RESULT unaffected;
  - START during the FIN cycle -> second operation starts, next DONE exactly 4 cycles later;
  - SHAMT=0 -> RESULT=DATA at t+4.
- RESET asserted at t+2 of an operation -> next cycle BUSY=0, DONE stays 0, RESULT=0.
- WIDTH=16, SHAMT_W=4, MODE=10, DATA=0x8000, SHAMT=15 -> DONE at t+5, RESULT=0xFFFF.
